adio_rx: RTL and testbench

- Serial audio receiver for the codec ADC path; the opposite direction of the existing DAC-side serializer.
- Frame format matches that serializer:
  - Left-justified, MSB-first, DATA_WIDTH bits per LRCK half.
  - LRCK high = left channel, LRCK low = right channel.
  - Receiver samples data on BCK rising edges.
- The codec is clock master. BCK, ADCLRCK and ADCDAT are asynchronous inputs, oversampled in the iCLK_18_4 domain.
- Output is a parallel stereo sample pair with a one-cycle valid strobe, plus lock and error status for downstream DSP/recording logic.

---
 rtl/adio_rx.sv | 168 ++++++++++++++++
 tb/tb_adio_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adio_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adio_rx                                                          |
// | Brief    : Left-justified serial audio receiver for the codec ADC path;     |
// |            oversamples BCK/LRCK/DAT and emits stereo pairs with status.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adio_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int LOCK_FRAMES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_ADCLRCK,
    input  logic                  iAUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    output logic                  oLOCK,
    output logic                  oFRAME_ERR
);

    localparam int                   c_CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [c_CNT_W-1:0]   c_FULL     = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]   c_OVF      = c_CNT_W'(DATA_WIDTH + 1);
    localparam logic [3:0]           c_LOCK_MAX = 4'(LOCK_FRAMES);
    localparam logic [7:0]           c_TMO      = 8'(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LEFT  = 2'd1;
    localparam logic [1:0] c_RIGHT = 2'd2;

    logic [2:0]            r_bck_sync;
    logic [2:0]            r_lr_sync;
    logic [1:0]            r_dat_sync;
    logic [1:0]            r_prime;
    logic [7:0]            r_wdog;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [c_CNT_W-1:0]    r_bitcnt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_left_good;
    logic [3:0]            r_lockcnt;
    logic [3:0]            w_lockcnt_nx;
    logic [DATA_WIDTH-1:0] r_left_out;
    logic [DATA_WIDTH-1:0] r_right_out;
    logic                  r_valid;
    logic                  r_lock;
    logic                  r_err;

    // Edges are masked until the synchronizers have refilled after reset,
    // otherwise the cleared pipeline would fake an edge on a high input.
    logic w_armed, w_bck_rise, w_bck_edge, w_lr_rise, w_lr_fall, w_lr_edge, w_dat;
    assign w_armed    = (r_prime == 2'd3);
    assign w_bck_edge = w_armed & (r_bck_sync[1] ^ r_bck_sync[2]);
    assign w_bck_rise = w_armed & r_bck_sync[1] & ~r_bck_sync[2];
    assign w_lr_edge  = w_armed & (r_lr_sync[1] ^ r_lr_sync[2]);
    assign w_lr_rise  = w_armed & r_lr_sync[1] & ~r_lr_sync[2];
    assign w_lr_fall  = w_armed & ~r_lr_sync[1] & r_lr_sync[2];
    assign w_dat      = r_dat_sync[1];

    logic w_tmo;
    assign w_tmo = ~w_bck_edge & (r_wdog >= c_TMO - 8'd1);

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_good;
    assign w_word = (r_bitcnt < c_FULL) ? (r_shreg << (c_FULL - r_bitcnt)) : r_shreg;
    assign w_good = (r_bitcnt == c_FULL);

    logic w_close_left, w_close_right, w_err;
    assign w_close_left  = ~w_tmo & (r_state == c_LEFT) & w_lr_fall;
    assign w_close_right = ~w_tmo & (r_state == c_RIGHT) & w_lr_rise;
    assign w_err         = ~w_tmo & w_lr_edge & (r_state != c_IDLE) & ~w_good;

    always_comb begin
        w_state_nx = r_state;
        if (w_tmo) begin
            w_state_nx = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_lr_rise) w_state_nx = c_LEFT;
                c_LEFT:  if (w_lr_fall) w_state_nx = c_RIGHT;
                c_RIGHT: if (w_lr_rise) w_state_nx = c_LEFT;
                default: w_state_nx = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_lockcnt_nx = r_lockcnt;
        if (w_tmo || w_err)
            w_lockcnt_nx = 4'd0;
        else if (w_close_right && r_left_good && r_lockcnt != c_LOCK_MAX)
            w_lockcnt_nx = r_lockcnt + 4'd1;
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) r_state <= c_IDLE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_bck_sync  <= '0;
            r_lr_sync   <= '0;
            r_dat_sync  <= '0;
            r_prime     <= '0;
            r_wdog      <= '0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_hold      <= '0;
            r_left_good <= 1'b0;
            r_lockcnt   <= '0;
            r_left_out  <= '0;
            r_right_out <= '0;
            r_valid     <= 1'b0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_bck_sync <= {r_bck_sync[1:0], iAUD_BCK};
            r_lr_sync  <= {r_lr_sync[1:0], iAUD_ADCLRCK};
            r_dat_sync <= {r_dat_sync[0], iAUD_ADCDAT};
            if (!w_armed) r_prime <= r_prime + 2'd1;

            if (w_bck_edge)          r_wdog <= '0;
            else if (r_wdog != c_TMO) r_wdog <= r_wdog + 8'd1;

            // A bit coinciding with an LRCK edge opens the new half.
            if (w_lr_edge) begin
                r_shreg  <= w_bck_rise ? {{(DATA_WIDTH-1){1'b0}}, w_dat} : '0;
                r_bitcnt <= w_bck_rise ? c_CNT_W'(1) : '0;
            end else if (w_bck_rise) begin
                if (r_bitcnt < c_FULL) begin
                    r_shreg  <= {r_shreg[DATA_WIDTH-2:0], w_dat};
                    r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                end else begin
                    r_bitcnt <= c_OVF;
                end
            end
            if (w_tmo) r_bitcnt <= '0;

            if (w_close_left) begin
                r_hold      <= w_word;
                r_left_good <= w_good;
            end
            if (w_close_right) begin
                r_left_out  <= r_hold;
                r_right_out <= w_word;
            end
            r_valid   <= w_close_right;
            r_err     <= w_err;
            r_lockcnt <= w_lockcnt_nx;
            r_lock    <= (w_lockcnt_nx == c_LOCK_MAX);
        end
    end

    assign oLEFT      = r_left_out;
    assign oRIGHT     = r_right_out;
    assign oVALID     = r_valid;
    assign oLOCK      = r_lock;
    assign oFRAME_ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adio_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_adio_rx                                                       |
// | Brief    : Self-checking bench for adio_rx against a frame-level model.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_adio_rx;

    localparam int DW  = 16;
    localparam int LF  = 4;
    localparam int TMO = 64;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          bck  = 1'b0;
    logic          lrck = 1'b0;
    logic          dat  = 1'b0;
    logic [DW-1:0] left, right;
    logic          valid, lock, ferr;

    always #27 clk = ~clk;

    adio_rx #(.DATA_WIDTH(DW), .LOCK_FRAMES(LF), .TIMEOUT(TMO)) dut (
        .iCLK_18_4   (clk),
        .iRST        (rst),
        .iAUD_BCK    (bck),
        .iAUD_ADCLRCK(lrck),
        .iAUD_ADCDAT (dat),
        .oLEFT       (left),
        .oRIGHT      (right),
        .oVALID      (valid),
        .oLOCK       (lock),
        .oFRAME_ERR  (ferr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame-level reference model: halves are closed by LRCK transitions.
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          lk;
        int            c;
    } exp_t;
    exp_t expq[$];

    typedef enum {M_IDLE, M_LEFT, M_RIGHT} mode_t;
    mode_t         mode     = M_IDLE;
    int            lockcnt  = 0;
    logic [DW-1:0] hold     = '0;
    bit            lgood    = 1'b0;
    longint        pend_val = 0;
    int            pend_n   = 0;
    bit            cur_lr   = 1'b0;
    int            last_edge = 0;
    int            obs_err  = 0;
    int            exp_err  = 0;

    function automatic logic [DW-1:0] word_of(input longint v, input int n);
        if (n < DW) return DW'(v << (DW - n));
        return DW'(v >> (n - DW));
    endfunction

    task automatic model_close(input bit rising);
        logic [DW-1:0] w;
        bit            g;
        w = word_of(pend_val, pend_n);
        g = (pend_n == DW);
        case (mode)
            M_IDLE: if (rising) mode = M_LEFT;
            M_LEFT: if (!rising) begin
                hold  = w;
                lgood = g;
                if (!g) begin exp_err++; lockcnt = 0; end
                mode = M_RIGHT;
            end
            M_RIGHT: if (rising) begin
                if (!g) begin exp_err++; lockcnt = 0; end
                else if (lgood && lockcnt < LF) lockcnt++;
                expq.push_back('{hold, w, (lockcnt == LF), cyc});
                mode = M_LEFT;
            end
            default: mode = M_IDLE;
        endcase
        pend_val = 0;
        pend_n   = 0;
    endtask

    task automatic model_drop();
        mode     = M_IDLE;
        lockcnt  = 0;
        pend_val = 0;
        pend_n   = 0;
    endtask

    // Codec-side driver: LRCK and DAT change while BCK is low, data sampled on BCK rise.
    task automatic set_lr(input bit lr);
        @(negedge clk);
        if (lr != cur_lr) begin
            lrck   = lr;
            model_close(lr);
            cur_lr = lr;
        end
    endtask

    task automatic send_bits(input int n, input longint v);
        for (int i = n - 1; i >= 0; i--) begin
            dat = v[i];
            repeat (6) @(negedge clk);
            bck = 1'b1;
            repeat (6) @(negedge clk);
            bck = 1'b0;
            last_edge = cyc;
        end
        if (pend_n < 40) begin
            pend_val = (pend_val << n) | v;
            pend_n   = pend_n + n;
        end
    endtask

    task automatic send_half(input bit lr, input int n, input longint v);
        set_lr(lr);
        send_bits(n, v);
    endtask

    task automatic frame(input longint l, input longint r);
        send_half(1'b1, DW, l);
        send_half(1'b0, DW, r);
    endtask

    function automatic longint rnd(input int n);
        return longint'($urandom) & ((longint'(1) << n) - 1);
    endfunction

    task automatic bck_stop(input int n);
        int  last;
        bit  exp_lock;
        last     = last_edge;
        exp_lock = (lockcnt == LF);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cyc == last + TMO + 2) check("lock_before_timeout", lock, exp_lock);
            if (cyc == last + TMO + 3) check("lock_at_timeout", lock, 0);
        end
        if (n >= TMO) model_drop();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_drop();
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_lock", lock, 0);
        check("rst_valid", valid, 0);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (expq.size() == 0) begin
                check("valid_unexpected", valid, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("left", left, e.l);
                check("right", right, e.r);
                check("lock", lock, e.lk);
                check("valid_latency", cyc - e.c, 3);
            end
        end
        if (ferr) begin
            obs_err++;
            check("lock_on_err", lock, 0);
        end
    end

    initial begin
        // startup: reset released mid right half
        repeat (5) @(negedge clk);
        check("rst0_left", left, 0);
        check("rst0_right", right, 0);
        check("rst0_valid", valid, 0);
        check("rst0_lock", lock, 0);
        check("rst0_err", ferr, 0);
        rst = 1'b0;
        send_bits(10, rnd(10));
        for (int i = 0; i < 5; i++) frame(64'hA5C3, 64'h1234);
        check("startup_err", obs_err, exp_err);
        check("nominal_lock", lock, 1);

        // short left half, then re-lock
        send_half(1'b1, 12, 64'hABC);
        send_half(1'b0, DW, 64'h1234);
        for (int i = 0; i < 5; i++) frame(rnd(DW), rnd(DW));
        check("short_err", obs_err, exp_err);

        // long left half
        send_half(1'b1, 18, 64'h3FFFC);
        send_half(1'b0, DW, rnd(DW));
        for (int i = 0; i < 2; i++) frame(rnd(DW), rnd(DW));
        check("long_err", obs_err, exp_err);

        // randomized half lengths
        for (int i = 0; i < 16; i++) begin
            int nl, nr;
            nl = ($urandom_range(3) == 0) ? int'($urandom_range(18, 12)) : DW;
            nr = ($urandom_range(3) == 0) ? int'($urandom_range(18, 12)) : DW;
            send_half(1'b1, nl, rnd(nl));
            send_half(1'b0, nr, rnd(nr));
        end
        check("random_err", obs_err, exp_err);

        // BCK stop after reaching lock, then restart
        for (int i = 0; i < 6; i++) frame(rnd(DW), rnd(DW));
        bck_stop(100);
        send_bits(6, rnd(6));
        for (int i = 0; i < 3; i++) frame(rnd(DW), rnd(DW));
        check("restart_err", obs_err, exp_err);

        // reset after 8 left bits
        send_half(1'b1, 8, rnd(8));
        reset_pulse();
        send_bits(8, rnd(8));
        send_half(1'b0, DW, rnd(DW));
        for (int i = 0; i < 2; i++) frame(rnd(DW), rnd(DW));
        send_half(1'b1, DW, rnd(DW));

        repeat (20) @(negedge clk);
        check("final_err", obs_err, exp_err);
        check("pending_valid", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
